// File: rtl/univ_sr_pkg.sv
// Shared mode encoding and helpers for the universal shift register.
package univ_sr_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_HOLD  = 3'd0;
   localparam mode_t MODE_SHL   = 3'd1;
   localparam mode_t MODE_SHR   = 3'd2;
   localparam mode_t MODE_ROL   = 3'd3;
   localparam mode_t MODE_ROR   = 3'd4;
   localparam mode_t MODE_LOAD  = 3'd5;
   localparam mode_t MODE_CLEAR = 3'd6;
   localparam mode_t MODE_ASR   = 3'd7;

   // Modes that move lane data and therefore count as a frame beat.
   function automatic logic is_shift(mode_t mode);
      return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_ROL) ||
             (mode == MODE_ROR) || (mode == MODE_ASR);
   endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle between a serial-link driver and the universal shift register.
interface univ_shift_reg_if #(
   parameter int unsigned N = 8,
   parameter int unsigned S = 1
);
   localparam int unsigned CW = $clog2(N / S + 1);

   logic          en;
   logic [2:0]    mode;
   logic [S-1:0]  sin;
   logic [N-1:0]  pdata_in;
   logic [N-1:0]  pdata_out;
   logic [S-1:0]  sout;
   logic [CW-1:0] beat_cnt;
   logic          frame_done;

   modport master (
      output en, mode, sin, pdata_in,
      input  pdata_out, sout, beat_cnt, frame_done
   );

   modport slave (
      input  en, mode, sin, pdata_in,
      output pdata_out, sout, beat_cnt, frame_done
   );
endinterface

// File: rtl/sr_beat_counter.sv
// Counts shift beats modulo BEATS and pulses done_pulse the cycle after the last beat.
module sr_beat_counter #(
   parameter  int unsigned BEATS = 8,
   localparam int unsigned CW    = $clog2(BEATS + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          beat,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          done_pulse
);

   localparam logic [CW-1:0] LastBeat = CW'(BEATS - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;

   always_comb begin
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (beat) begin
         if (cnt_q == LastBeat) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign cnt        = cnt_q;
   assign done_pulse = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: S-bit lane shifts/rotates, parallel load/clear, and beat framing.
module univ_shift_reg
   import univ_sr_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned S = 1
) (
   input logic             clk,
   input logic             reset,
   univ_shift_reg_if.slave bus
);

   if (N < 2 || S < 1 || S > N || (N % S) != 0) begin : g_bad_params
      $error("univ_shift_reg: illegal parameters N=%0d S=%0d", N, S);
   end

   logic [N-1:0] q_q, q_d;
   logic [S-1:0] sout_q, sout_d;
   logic [N-1:0] shl_q, shr_q, rol_q, ror_q, asr_q;
   logic         beat, clr;

   // With a full-width lane the slice forms collapse, so they get their own branch.
   if (S < N) begin : g_lane
      assign shl_q = {q_q[N-S-1:0], bus.sin};
      assign shr_q = {bus.sin, q_q[N-1:S]};
      assign rol_q = {q_q[N-S-1:0], q_q[N-1-:S]};
      assign ror_q = {q_q[S-1:0], q_q[N-1:S]};
      assign asr_q = {{S{q_q[N-1]}}, q_q[N-1:S]};
   end else begin : g_full
      assign shl_q = bus.sin;
      assign shr_q = bus.sin;
      assign rol_q = q_q;
      assign ror_q = q_q;
      assign asr_q = {N{q_q[N-1]}};
   end

   always_comb begin
      q_d    = q_q;
      sout_d = sout_q;
      if (bus.en) begin
         case (bus.mode)
            MODE_SHL:   begin q_d = shl_q; sout_d = q_q[N-1-:S]; end
            MODE_SHR:   begin q_d = shr_q; sout_d = q_q[S-1:0];  end
            MODE_ROL:   begin q_d = rol_q; sout_d = q_q[N-1-:S]; end
            MODE_ROR:   begin q_d = ror_q; sout_d = q_q[S-1:0];  end
            MODE_ASR:   begin q_d = asr_q; sout_d = q_q[S-1:0];  end
            MODE_LOAD:  q_d = bus.pdata_in;
            MODE_CLEAR: begin q_d = '0; sout_d = '0; end
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q    <= '0;
         sout_q <= '0;
      end else begin
         q_q    <= q_d;
         sout_q <= sout_d;
      end
   end

   assign beat = bus.en && is_shift(bus.mode);
   assign clr  = bus.en && ((bus.mode == MODE_LOAD) || (bus.mode == MODE_CLEAR));

   sr_beat_counter #(
      .BEATS (N / S)
   ) u_beat_counter (
      .clk        (clk),
      .reset      (reset),
      .beat       (beat),
      .clr        (clr),
      .cnt        (bus.beat_cnt),
      .done_pulse (bus.frame_done)
   );

   assign bus.pdata_out = q_q;
   assign bus.sout      = sout_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed vector tables plus random traffic against an arithmetic model.
module tb_univ_shift_reg;
   import univ_sr_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   univ_shift_reg_if #(.N(8), .S(1)) b1 ();
   univ_shift_reg_if #(.N(8), .S(2)) b2 ();
   univ_shift_reg_if #(.N(4), .S(4)) b3 ();

   univ_shift_reg #(.N(8), .S(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
   univ_shift_reg #(.N(8), .S(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
   univ_shift_reg #(.N(4), .S(4)) dut3 (.clk(clk), .reset(reset), .bus(b3));

   typedef struct {
      int q;
      int sout;
      int cnt;
      int done;
   } model_t;

   typedef struct {
      int mode;
      int sin;
      int pdata;
      int q;
      int sout;
      int cnt;
      int done;
   } vec_t;

   int     total = 0;
   int     bad   = 0;
   model_t m1, m2, m3;
   vec_t   vecs[$];
   mode_t  shift_modes[5] = '{MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR};

   task automatic check(input string name, input logic [31:0] got, input int exp);
      total++;
      if (got !== 32'(exp)) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic cmp_model(input string tag, input model_t m, input logic [31:0] q,
                            input logic [31:0] so, input logic [31:0] c, input logic [31:0] d);
      check({tag, " q"}, q, m.q);
      check({tag, " sout"}, so, m.sout);
      check({tag, " cnt"}, c, m.cnt);
      check({tag, " done"}, d, m.done);
   endtask

   // Register treated as an integer; lanes move by multiplying/dividing by 2**s.
   function automatic model_t step(model_t m, int n, int s, logic en, mode_t mode, int sin,
                                   int pd);
      model_t r;
      int     mask, smask, lo, hi;
      bit     shift;
      mask   = (1 << n) - 1;
      smask  = (1 << s) - 1;
      r      = m;
      r.done = 0;
      if (en !== 1'b1) return r;
      lo    = m.q & smask;
      hi    = (m.q >> (n - s)) & smask;
      shift = 1'b1;
      case (mode)
         MODE_SHL: begin r.q = ((m.q << s) | (sin & smask)) & mask; r.sout = hi; end
         MODE_SHR: begin r.q = (m.q >> s) | ((sin & smask) << (n - s)); r.sout = lo; end
         MODE_ROL: begin r.q = ((m.q << s) | hi) & mask; r.sout = hi; end
         MODE_ROR: begin r.q = (m.q >> s) | (lo << (n - s)); r.sout = lo; end
         MODE_ASR: begin
            r.q = m.q >> s;
            if (((m.q >> (n - 1)) & 1) == 1) r.q = r.q | (mask & ~(mask >> s));
            r.sout = lo;
         end
         MODE_LOAD:  begin r.q = pd & mask; r.cnt = 0; shift = 1'b0; end
         MODE_CLEAR: begin r.q = 0; r.sout = 0; r.cnt = 0; shift = 1'b0; end
         default:    shift = 1'b0;
      endcase
      if (shift) begin
         if (m.cnt + 1 == n / s) begin
            r.cnt  = 0;
            r.done = 1;
         end else begin
            r.cnt = m.cnt + 1;
         end
      end
      return r;
   endfunction

   function automatic vec_t mk(int mode, int sin, int pdata, int q, int so, int c, int d);
      vec_t v;
      v.mode = mode; v.sin = sin; v.pdata = pdata;
      v.q = q; v.sout = so; v.cnt = c; v.done = d;
      return v;
   endfunction

   function automatic mode_t pick_mode();
      int r;
      r = $urandom_range(0, 19);
      if (r < 2) return MODE_LOAD;
      if (r == 2) return MODE_CLEAR;
      if (r == 3) return MODE_HOLD;
      return shift_modes[$urandom_range(0, 4)];
   endfunction

   task automatic idle_all();
      b1.en = 1'b0; b1.mode = MODE_HOLD; b1.sin = '0; b1.pdata_in = '0;
      b2.en = 1'b0; b2.mode = MODE_HOLD; b2.sin = '0; b2.pdata_in = '0;
      b3.en = 1'b0; b3.mode = MODE_HOLD; b3.sin = '0; b3.pdata_in = '0;
   endtask

   task automatic check_zero1(input string tag);
      check({tag, " q"}, 32'(b1.pdata_out), 0);
      check({tag, " sout"}, 32'(b1.sout), 0);
      check({tag, " cnt"}, 32'(b1.beat_cnt), 0);
      check({tag, " done"}, 32'(b1.frame_done), 0);
   endtask

   task automatic tick_all(input string tag);
      m1 = step(m1, 8, 1, b1.en, b1.mode, int'(b1.sin), int'(b1.pdata_in));
      m2 = step(m2, 8, 2, b2.en, b2.mode, int'(b2.sin), int'(b2.pdata_in));
      m3 = step(m3, 4, 4, b3.en, b3.mode, int'(b3.sin), int'(b3.pdata_in));
      @(negedge clk);
      cmp_model({tag, " n8s1"}, m1, 32'(b1.pdata_out), 32'(b1.sout), 32'(b1.beat_cnt),
                32'(b1.frame_done));
      cmp_model({tag, " n8s2"}, m2, 32'(b2.pdata_out), 32'(b2.sout), 32'(b2.beat_cnt),
                32'(b2.frame_done));
      cmp_model({tag, " n4s4"}, m3, 32'(b3.pdata_out), 32'(b3.sout), 32'(b3.beat_cnt),
                32'(b3.frame_done));
   endtask

   initial begin
      int ror_q[4], ror_s[4], ror_c[4], ror_d[4];

      // LOAD B4 then 8 SHL: sout streams the MSB-first bits, pulse after beat 8.
      vecs.push_back(mk(5, 0, 'hB4, 'hB4, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 'h68, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0, 'hD0, 0, 2, 0));
      vecs.push_back(mk(1, 0, 0, 'hA0, 1, 3, 0));
      vecs.push_back(mk(1, 0, 0, 'h40, 1, 4, 0));
      vecs.push_back(mk(1, 0, 0, 'h80, 0, 5, 0));
      vecs.push_back(mk(1, 0, 0, 'h00, 1, 6, 0));
      vecs.push_back(mk(1, 0, 0, 'h00, 0, 7, 0));
      vecs.push_back(mk(1, 0, 0, 'h00, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 'h00, 0, 0, 0));
      // Arithmetic shift replicates the sign bit.
      vecs.push_back(mk(5, 0, 'h80, 'h80, 0, 0, 0));
      vecs.push_back(mk(7, 0, 0, 'hC0, 0, 1, 0));
      vecs.push_back(mk(7, 0, 0, 'hE0, 0, 2, 0));
      vecs.push_back(mk(7, 0, 0, 'hF0, 0, 3, 0));
      // LOAD after 5 beats abandons the frame; a fresh 8 beats give one pulse.
      vecs.push_back(mk(5, 0, 'h00, 'h00, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 'h01, 0, 1, 0));
      vecs.push_back(mk(1, 1, 0, 'h03, 0, 2, 0));
      vecs.push_back(mk(1, 1, 0, 'h07, 0, 3, 0));
      vecs.push_back(mk(1, 1, 0, 'h0F, 0, 4, 0));
      vecs.push_back(mk(1, 1, 0, 'h1F, 0, 5, 0));
      vecs.push_back(mk(5, 0, 'h3C, 'h3C, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 'h78, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 'hF0, 0, 2, 0));
      vecs.push_back(mk(1, 0, 0, 'hE0, 1, 3, 0));
      vecs.push_back(mk(1, 0, 0, 'hC0, 1, 4, 0));
      vecs.push_back(mk(1, 0, 0, 'h80, 1, 5, 0));
      vecs.push_back(mk(1, 0, 0, 'h00, 1, 6, 0));
      vecs.push_back(mk(1, 0, 0, 'h00, 0, 7, 0));
      vecs.push_back(mk(1, 0, 0, 'h00, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 'h00, 0, 0, 0));

      ror_q = '{'h60, 'h18, 'h06, 'h81};
      ror_s = '{1, 0, 0, 2};
      ror_c = '{1, 2, 3, 0};
      ror_d = '{0, 0, 0, 1};

      reset = 1'b1;
      idle_all();
      #12;
      check_zero1("por");
      @(negedge clk);
      reset = 1'b0;

      // Async reset mid-shift clears everything without a clock edge.
      b1.en = 1'b1; b1.mode = MODE_LOAD; b1.pdata_in = 8'hA5;
      @(negedge clk);
      check("t1 load q", 32'(b1.pdata_out), 'hA5);
      b1.mode = MODE_SHL; b1.sin = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_zero1("t1 async");
      @(negedge clk);
      idle_all();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_zero1("t1 idle");

      foreach (vecs[i]) begin
         b1.en       = 1'b1;
         b1.mode     = 3'(vecs[i].mode);
         b1.sin      = 1'(vecs[i].sin);
         b1.pdata_in = 8'(vecs[i].pdata);
         @(negedge clk);
         check($sformatf("vec%0d q", i), 32'(b1.pdata_out), vecs[i].q);
         check($sformatf("vec%0d sout", i), 32'(b1.sout), vecs[i].sout);
         check($sformatf("vec%0d cnt", i), 32'(b1.beat_cnt), vecs[i].cnt);
         check($sformatf("vec%0d done", i), 32'(b1.frame_done), vecs[i].done);
      end
      idle_all();

      // Two-bit lanes: four rotates bring 8'h81 back home and close one frame.
      b2.en = 1'b1; b2.mode = MODE_LOAD; b2.pdata_in = 8'h81;
      @(negedge clk);
      check("t3 load q", 32'(b2.pdata_out), 'h81);
      check("t3 load cnt", 32'(b2.beat_cnt), 0);
      b2.mode = MODE_ROR;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("t3 ror%0d q", i), 32'(b2.pdata_out), ror_q[i]);
         check($sformatf("t3 ror%0d sout", i), 32'(b2.sout), ror_s[i]);
         check($sformatf("t3 ror%0d cnt", i), 32'(b2.beat_cnt), ror_c[i]);
         check($sformatf("t3 ror%0d done", i), 32'(b2.frame_done), ror_d[i]);
      end
      b2.mode = MODE_HOLD;
      @(negedge clk);
      check("t3 hold done", 32'(b2.frame_done), 0);
      idle_all();

      // Known starting point for the model: CLEAR every instance.
      m1 = '{0, 0, 0, 0};
      m2 = '{0, 0, 0, 0};
      m3 = '{0, 0, 0, 0};
      b1.en = 1'b1; b1.mode = MODE_CLEAR;
      b2.en = 1'b1; b2.mode = MODE_CLEAR;
      b3.en = 1'b1; b3.mode = MODE_CLEAR;
      tick_all("t6 clr");
      idle_all();

      // Freeze mid-frame with en low while mode still says SHL.
      b1.en = 1'b1; b1.mode = MODE_LOAD; b1.pdata_in = 8'h5A;
      tick_all("t6 load");
      b1.mode = MODE_SHL;
      for (int i = 0; i < 3; i++) begin
         b1.sin = 1'($urandom);
         tick_all("t6 shl");
      end
      b1.en = 1'b0;
      for (int i = 0; i < 3; i++) tick_all("t6 frz");

      for (int i = 0; i < 300; i++) begin
         b1.en = ($urandom_range(0, 9) != 0); b1.mode = pick_mode();
         b1.sin = 1'($urandom); b1.pdata_in = 8'($urandom);
         b2.en = ($urandom_range(0, 9) != 0); b2.mode = pick_mode();
         b2.sin = 2'($urandom); b2.pdata_in = 8'($urandom);
         b3.en = ($urandom_range(0, 9) != 0); b3.mode = pick_mode();
         b3.sin = 4'($urandom); b3.pdata_in = 4'($urandom);
         tick_all($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
